// File: rtl/wb_pkg.sv
// Shared defaults for the writeback arbiter: requester count, data/address widths, grant-index width.
// Pure declarations, no logic; latency and backpressure are defined by the users of this package.
package wb_pkg;
    localparam int NREQ_DEF = 3;
    localparam int XLEN_DEF = 32;
    localparam int AW_DEF   = 5;

    // Width of a requester index; never less than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int GW_DEF = idx_w(NREQ_DEF);
endpackage

// File: rtl/rr_pick.sv
// Cyclic priority pick: first valid index at or after ptr, wrapping; one-hot grant plus its index.
// Purely combinational (zero latency); no backpressure of its own, the caller gates the result.
module rr_pick
    import wb_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int GW   = idx_w(NREQ)
) (
    input  logic [NREQ-1:0] valid,
    input  logic [GW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [GW-1:0]   idx
);
    int   j;
    logic found;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int i = 0; i < NREQ; i++) begin
            // ptr is always below NREQ, so one subtraction is enough to wrap.
            j = int'(ptr) + i;
            if (j >= NREQ) begin
                j = j - NREQ;
            end
            if (!found && valid[j]) begin
                grant[j] = 1'b1;
                idx      = GW'(j);
                found    = 1'b1;
            end
        end
    end
endmodule

// File: rtl/wb_arbiter.sv
// Round-robin arbiter merging NREQ writeback requesters onto one registered register-file write port.
// One-cycle latency from accept to rf_we; rf_stall freezes the output stage and withholds all req_ready.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int XLEN = XLEN_DEF,
    parameter int AW   = AW_DEF,
    parameter int GW   = idx_w(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*AW-1:0]   req_rd,
    input  logic [NREQ*XLEN-1:0] req_data,
    output logic [NREQ-1:0]      req_ready,
    input  logic                 rf_stall,
    output logic                 rf_we,
    output logic [AW-1:0]        rf_waddr,
    output logic [XLEN-1:0]      rf_wdata,
    output logic [GW-1:0]        grant_id
);
    logic [GW-1:0]   ptr;
    logic [GW-1:0]   ptr_nxt;
    logic [GW-1:0]   pick_idx;
    logic [NREQ-1:0] pick_grant;
    logic            xfer;
    logic [AW-1:0]   sel_rd;
    logic [XLEN-1:0] sel_data;

    rr_pick #(
        .NREQ (NREQ),
        .GW   (GW)
    ) u_pick (
        .valid (req_valid),
        .ptr   (ptr),
        .grant (pick_grant),
        .idx   (pick_idx)
    );

    assign req_ready = (rst || rf_stall) ? '0 : pick_grant;
    assign xfer      = |req_ready;
    assign sel_rd    = req_rd[int'(pick_idx)*AW +: AW];
    assign sel_data  = req_data[int'(pick_idx)*XLEN +: XLEN];
    assign ptr_nxt   = (pick_idx == GW'(NREQ-1)) ? '0 : pick_idx + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr      <= '0;
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
            grant_id <= '0;
        end else if (!rf_stall) begin
            if (xfer) begin
                // Writes to x0 are consumed but never reach the register file.
                rf_we    <= (sel_rd != '0);
                rf_waddr <= sel_rd;
                rf_wdata <= sel_data;
                grant_id <= pick_idx;
                ptr      <= ptr_nxt;
            end else begin
                rf_we    <= 1'b0;
            end
        end
    end
endmodule
